// File: rtl/phase_tracker.sv
// phase_tracker: steers the DCO phase increment so SIN_MUL_ACC nulls while COS_MUL_ACC stays positive.
// Optional macro PHASE_TRACKER_HALF_PLANE_EN forces an upward escape step whenever COS_MUL_ACC <= 0.
module phase_tracker #(
    parameter int PHASE_INCREMENT_BITS = 28,
    parameter int RESULT_MUL_ACC_WIDTH = 36,
    parameter int SETTLE_CYCLES        = 1024,
    parameter int GAIN_SHIFT           = 12,
    parameter int MAX_STEP             = 4096,
    parameter logic [PHASE_INCREMENT_BITS-1:0] MIN_PHASE_INCREMENT = 28'h0010000,
    parameter logic [PHASE_INCREMENT_BITS-1:0] MAX_PHASE_INCREMENT = 28'h4000000,
    parameter int LOCK_THRESHOLD       = 1024,
    parameter int LOCK_COUNT           = 8
) (
    input  logic                                   CLK,
    input  logic                                   RESET_N,
    input  logic                                   CE,
    input  logic                                   ENABLE,
    input  logic [PHASE_INCREMENT_BITS-1:0]        START_PHASE_INCREMENT,
    input  logic signed [RESULT_MUL_ACC_WIDTH-1:0] SIN_MUL_ACC,
    input  logic signed [RESULT_MUL_ACC_WIDTH-1:0] COS_MUL_ACC,
    output logic [PHASE_INCREMENT_BITS-1:0]        PHASE_INCREMENT_OUT,
    output logic                                   UPDATED,
    output logic                                   LOCKED
);
    localparam int PW = PHASE_INCREMENT_BITS + 2;
    localparam int RW = RESULT_MUL_ACC_WIDTH;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam logic [SW-1:0]        SETTLE_RELOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [LW-1:0]        LOCK_FULL     = LW'(LOCK_COUNT);
    localparam logic [RW:0]          LOCK_TH       = (RW+1)'(LOCK_THRESHOLD);
    localparam logic signed [RW+1:0] STEP_MAX      = (RW+2)'(MAX_STEP);
    localparam logic signed [RW+1:0] STEP_MIN      = -STEP_MAX;
    localparam logic signed [PW-1:0] INC_MIN       = $signed({2'b00, MIN_PHASE_INCREMENT});
    localparam logic signed [PW-1:0] INC_MAX       = $signed({2'b00, MAX_PHASE_INCREMENT});

    // IDLE: follow START | SETTLE: wait for filters | SAMPLE: latch | CALC: form step | APPLY: update
    typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_CALC, ST_APPLY} state_t;

    state_t                          state_q, state_d;
    logic [SW-1:0]                   settle_cnt_q, settle_cnt_d;
    logic [LW-1:0]                   lock_cnt_q, lock_cnt_d;
    logic [PHASE_INCREMENT_BITS-1:0] phase_q, phase_d;
    logic                            updated_q, updated_d;
    logic                            locked_q, locked_d;
    logic signed [RW-1:0]            s_err_q, s_err_d;
    logic signed [RW-1:0]            c_ref_q, c_ref_d;
    logic signed [PW-1:0]            step_q, step_d;

    logic signed [RW-1:0]            shifted;
    logic signed [RW+1:0]            shifted_x;
    logic signed [RW+1:0]            sat;
    logic [RW:0]                     s_ext;
    logic [RW:0]                     abs_s;
    logic                            cos_pos;
    logic                            lock_hit;
    logic signed [PW-1:0]            new_x;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        lock_cnt_d   = lock_cnt_q;
        phase_d      = phase_q;
        updated_d    = updated_q;
        locked_d     = locked_q;
        s_err_d      = s_err_q;
        c_ref_d      = c_ref_q;
        step_d       = step_q;

        shifted   = s_err_q >>> GAIN_SHIFT;
        shifted_x = {{2{shifted[RW-1]}}, shifted};
        if (shifted_x > STEP_MAX)
            sat = STEP_MAX;
        else if (shifted_x < STEP_MIN)
            sat = STEP_MIN;
        else
            sat = shifted_x;

        // one extra bit keeps |most-negative| representable
        s_ext    = {s_err_q[RW-1], s_err_q};
        abs_s    = s_ext[RW] ? (~s_ext + 1'b1) : s_ext;
        cos_pos  = !c_ref_q[RW-1] && (c_ref_q != '0);
        lock_hit = (abs_s < LOCK_TH) && cos_pos;
        new_x    = $signed({2'b00, phase_q}) - step_q;

        if (CE) begin
            updated_d = 1'b0;
            if (state_q != ST_IDLE && !ENABLE) begin
                state_d    = ST_IDLE;
                phase_d    = START_PHASE_INCREMENT;
                lock_cnt_d = '0;
                locked_d   = 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        phase_d    = START_PHASE_INCREMENT;
                        lock_cnt_d = '0;
                        locked_d   = 1'b0;
                        if (ENABLE) begin
                            state_d      = ST_SETTLE;
                            settle_cnt_d = SETTLE_RELOAD;
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_cnt_q == '0)
                            state_d = ST_SAMPLE;
                        else
                            settle_cnt_d = settle_cnt_q - 1'b1;
                    end
                    ST_SAMPLE: begin
                        s_err_d = SIN_MUL_ACC;
                        c_ref_d = COS_MUL_ACC;
                        state_d = ST_CALC;
                    end
                    ST_CALC: begin
                        step_d = PW'(sat);
`ifdef PHASE_TRACKER_HALF_PLANE_EN
                        if (!cos_pos) begin
                            step_d     = PW'(STEP_MIN);
                            lock_cnt_d = '0;
                        end
`endif
                        state_d = ST_APPLY;
                    end
                    ST_APPLY: begin
                        if (new_x < INC_MIN)
                            phase_d = MIN_PHASE_INCREMENT;
                        else if (new_x > INC_MAX)
                            phase_d = MAX_PHASE_INCREMENT;
                        else
                            phase_d = new_x[PHASE_INCREMENT_BITS-1:0];
                        updated_d = 1'b1;
                        if (lock_hit)
                            lock_cnt_d = (lock_cnt_q == LOCK_FULL) ? LOCK_FULL : lock_cnt_q + 1'b1;
                        else
                            lock_cnt_d = '0;
                        locked_d     = (lock_cnt_d == LOCK_FULL);
                        state_d      = ST_SETTLE;
                        settle_cnt_d = SETTLE_RELOAD;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            lock_cnt_q   <= '0;
            phase_q      <= MIN_PHASE_INCREMENT;
            updated_q    <= 1'b0;
            locked_q     <= 1'b0;
            s_err_q      <= '0;
            c_ref_q      <= '0;
            step_q       <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            phase_q      <= phase_d;
            updated_q    <= updated_d;
            locked_q     <= locked_d;
            s_err_q      <= s_err_d;
            c_ref_q      <= c_ref_d;
            step_q       <= step_d;
        end
    end

    assign PHASE_INCREMENT_OUT = phase_q;
    assign UPDATED             = updated_q;
    assign LOCKED              = locked_q;
endmodule

// File: tb/tb_phase_tracker.sv
// tb_phase_tracker: scoreboard bench for phase_tracker (SETTLE_CYCLES=16, GAIN_SHIFT=8).
// Honours PHASE_TRACKER_HALF_PLANE_EN in its reference model.
module tb_phase_tracker;
    localparam int     GS   = 8;
    localparam int     SC   = 16;
    localparam longint MAXS = 4096;
    localparam longint LT   = 1024;
    localparam int     LC   = 8;
    localparam longint PMIN = 64'h0010000;
    localparam longint PMAX = 64'h4000000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               ce;
    logic               enable;
    logic [27:0]        start_inc;
    logic signed [35:0] sin_acc;
    logic signed [35:0] cos_acc;
    logic [27:0]        phase_out;
    logic               updated;
    logic               locked;

    int errors = 0;
    int checks = 0;
    bit ce_toggle = 1'b0;

    typedef struct {
        logic [27:0] phase;
        logic        locked;
    } exp_t;
    exp_t   sb[$];
    longint m_phase;
    int     m_cnt;

    always #5 clk = ~clk;

    phase_tracker #(
        .SETTLE_CYCLES(SC),
        .GAIN_SHIFT(GS)
    ) dut (
        .CLK(clk),
        .RESET_N(rst_n),
        .CE(ce),
        .ENABLE(enable),
        .START_PHASE_INCREMENT(start_inc),
        .SIN_MUL_ACC(sin_acc),
        .COS_MUL_ACC(cos_acc),
        .PHASE_INCREMENT_OUT(phase_out),
        .UPDATED(updated),
        .LOCKED(locked)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        if (ce_toggle) ce = ~ce;
    endtask

    // reference model: push the expected result of the next update
    task automatic predict();
        longint s, c, st, nv, a;
        exp_t   e;
        s  = sin_acc;
        c  = cos_acc;
        st = s >>> GS;
`ifdef PHASE_TRACKER_HALF_PLANE_EN
        if (c <= 0) st = -MAXS;
`endif
        if (st > MAXS) st = MAXS;
        else if (st < -MAXS) st = -MAXS;
        nv = m_phase - st;
        if (nv < PMIN) nv = PMIN;
        else if (nv > PMAX) nv = PMAX;
        m_phase = nv;
        a = (s < 0) ? -s : s;
        if (a < LT && c > 0) m_cnt = (m_cnt == LC) ? LC : m_cnt + 1;
        else m_cnt = 0;
        e.phase  = 28'(nv);
        e.locked = (m_cnt == LC);
        sb.push_back(e);
    endtask

    task automatic wait_update(output int cyc);
        logic prev;
        prev = updated;
        cyc  = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            cyc++;
            if (updated && !prev) return;
            prev = updated;
        end
        errors++;
        checks++;
        $display("FAIL update_timeout: no UPDATED rise within 200 cycles");
        cyc = -1;
    endtask

    task automatic restart(input logic [27:0] st, input logic signed [35:0] s, input logic signed [35:0] c);
        enable = 1'b0;
        tick();
        tick();
        start_inc = st;
        sin_acc   = s;
        cos_acc   = c;
        tick();
        m_phase = st;
        m_cnt   = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        int   cyc;
        exp_t e;
        rst_n = 1'b0; ce = 1'b1; enable = 1'b0;
        start_inc = 28'h0100000; sin_acc = 36'sd25600; cos_acc = 36'sd1000;
        #12;
        checks++; if (phase_out !== 28'(PMIN)) begin errors++; $display("FAIL reset_phase: got %h want %h", phase_out, 28'(PMIN)); end
        checks++; if (updated !== 1'b0) begin errors++; $display("FAIL reset_updated: got %b want 0", updated); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
        rst_n = 1'b1;
        tick();
        checks++; if (phase_out !== 28'h0100000) begin errors++; $display("FAIL idle_start: got %h want 0100000", phase_out); end
        enable = 1'b1;
        repeat (6) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (phase_out !== 28'(PMIN)) begin errors++; $display("FAIL async_reset_phase: got %h want %h", phase_out, 28'(PMIN)); end
        checks++; if (updated !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL async_reset_flags: got %b%b want 00", updated, locked); end
        tick();
        rst_n = 1'b1;
        tick();
        m_phase = 28'h0100000; m_cnt = 0; sb.delete();
        predict();
        wait_update(cyc);
        e = sb.pop_front();
        checks++; if (cyc !== 19) begin errors++; $display("FAIL post_reset_latency: got %0d want 19", cyc); end
        checks++; if (phase_out !== e.phase) begin errors++; $display("FAIL post_reset_value: got %h want %h", phase_out, e.phase); end
    endtask

    task automatic test_basic_step();
        int          cyc;
        exp_t        e;
        logic [27:0] lit [2];
        lit[0] = 28'h00FFF9C;
        lit[1] = 28'h00FFF38;
        restart(28'h0100000, 36'sd25600, 36'sd1000);
        enable = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            predict();
            wait_update(cyc);
            e = sb.pop_front();
            checks++; if (cyc !== 19) begin errors++; $display("FAIL basic_period%0d: got %0d want 19", k, cyc); end
            checks++; if (phase_out !== e.phase || phase_out !== lit[k]) begin errors++; $display("FAIL basic_value%0d: got %h want %h", k, phase_out, lit[k]); end
            checks++; if (locked !== e.locked) begin errors++; $display("FAIL basic_locked%0d: got %b want %b", k, locked, e.locked); end
        end
        tick();
        checks++; if (updated !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %b want 0", updated); end
        sin_acc = -36'sd100;
        predict();
        wait_update(cyc);
        e = sb.pop_front();
        checks++; if (phase_out !== e.phase) begin errors++; $display("FAIL floor_rounding: got %h want %h", phase_out, e.phase); end
    endtask

    task automatic test_saturation();
        int          cyc;
        exp_t        e;
        logic [27:0] prev;
        restart(28'h0100000, 36'sh800000000, 36'sd1000);
        enable = 1'b1;
        tick();
        prev = 28'h0100000;
        for (int k = 0; k < 3; k++) begin
            predict();
            wait_update(cyc);
            e = sb.pop_front();
            checks++; if (phase_out !== e.phase || phase_out - prev !== 28'd4096) begin errors++; $display("FAIL sat_step%0d: got %h want %h", k, phase_out, e.phase); end
            prev = phase_out;
        end
        restart(28'(PMAX - 100), 36'sh800000000, 36'sd1000);
        enable = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            predict();
            wait_update(cyc);
            e = sb.pop_front();
            checks++; if (phase_out !== e.phase || phase_out !== 28'(PMAX)) begin errors++; $display("FAIL clamp_max%0d: got %h want %h", k, phase_out, 28'(PMAX)); end
        end
        restart(28'(PMIN + 50), 36'sd1048576, 36'sd1000);
        enable = 1'b1;
        tick();
        predict();
        wait_update(cyc);
        e = sb.pop_front();
        checks++; if (phase_out !== e.phase || phase_out !== 28'(PMIN)) begin errors++; $display("FAIL clamp_min: got %h want %h", phase_out, 28'(PMIN)); end
    endtask

    task automatic test_lock();
        int   cyc;
        exp_t e;
        restart(28'h0100000, 36'sd500, 36'sd1000);
        enable = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            sin_acc = (k == 9) ? 36'sd5000 : 36'sd500;
            predict();
            wait_update(cyc);
            e = sb.pop_front();
            checks++; if (locked !== e.locked) begin errors++; $display("FAIL lock_update%0d: got %b want %b", k, locked, e.locked); end
            checks++; if (phase_out !== e.phase) begin errors++; $display("FAIL lock_value%0d: got %h want %h", k, phase_out, e.phase); end
        end
    endtask

    task automatic test_ce_gating();
        int          cyc;
        exp_t        e;
        logic [27:0] held;
        ce = 1'b1;
        restart(28'h0100000, 36'sd25600, 36'sd1000);
        ce_toggle = 1'b1;
        enable = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            predict();
            wait_update(cyc);
            e = sb.pop_front();
            checks++; if (cyc !== 38) begin errors++; $display("FAIL ce_period%0d: got %0d want 38", k, cyc); end
            checks++; if (phase_out !== e.phase) begin errors++; $display("FAIL ce_value%0d: got %h want %h", k, phase_out, e.phase); end
        end
        ce_toggle = 1'b0;
        held = phase_out;
        enable = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        checks++; if (phase_out !== held || updated !== 1'b1) begin errors++; $display("FAIL ce_freeze: got %h/%b want %h/1", phase_out, updated, held); end
        ce = 1'b1;
        predict();
        wait_update(cyc);
        e = sb.pop_front();
        checks++; if (phase_out !== e.phase) begin errors++; $display("FAIL ce_resume: got %h want %h", phase_out, e.phase); end
    endtask

    task automatic test_abort();
        int   cyc;
        exp_t e;
        bit   seen;
        ce = 1'b1;
        restart(28'h0100000, 36'sd25600, 36'sd1000);
        enable = 1'b1;
        tick();
        predict();
        wait_update(cyc);
        e = sb.pop_front();
        checks++; if (phase_out !== e.phase) begin errors++; $display("FAIL abort_pre: got %h want %h", phase_out, e.phase); end
        start_inc = 28'h0200000;
        repeat (17) tick();
        enable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (updated) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_pulse: got %b want 0", seen); end
        checks++; if (phase_out !== 28'h0200000 || locked !== 1'b0) begin errors++; $display("FAIL abort_start: got %h/%b want 0200000/0", phase_out, locked); end
    endtask

    task automatic test_half_plane();
        int   cyc;
        exp_t e;
        restart(28'h0100000, 36'sd0, -36'sd1000);
        enable = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            cos_acc = (k == 3) ? 36'sd0 : -36'sd1000;
            predict();
            wait_update(cyc);
            e = sb.pop_front();
            checks++; if (phase_out !== e.phase) begin errors++; $display("FAIL half_plane_value%0d: got %h want %h", k, phase_out, e.phase); end
            checks++; if (locked !== 1'b0) begin errors++; $display("FAIL half_plane_locked%0d: got %b want 0", k, locked); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_step();
        test_saturation();
        test_lock();
        test_ce_gating();
        test_abort();
        test_half_plane();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
